// File: rtl/lava_channel_scheduler.sv
// Round-robin scheduler: picks one sampling channel per cycle and emits a {channel, value, index} token when the sample moved by THRESHOLD or more.
// Optional build macro LAVA_SCHED_FORCE_FIRST_EN: always emit the index-0 sample of each frame.
module lava_channel_scheduler #(
    parameter int NUM_CHANNELS        = 4,
    parameter int DATA_BITS           = 10,
    parameter int THRESHOLD           = 20,
    parameter int SAMPLES_PER_CHANNEL = 3328,
    localparam int CH_W  = $clog2(NUM_CHANNELS),
    localparam int IDX_W = $clog2(SAMPLES_PER_CHANNEL),
    localparam int TOK_W = CH_W + DATA_BITS + IDX_W
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] ch_data_i,
    input  logic [NUM_CHANNELS-1:0]           ch_valid_i,
    output logic [NUM_CHANNELS-1:0]           ch_ready_o,
    output logic [TOK_W-1:0]                  data_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              frame_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [CH_W-1:0]        last_grant_reg;
    logic [TOK_W-1:0]       data_reg;
    logic                   valid_reg;
    logic                   valid_next;
    logic                   frame_done_reg;

    logic                   can_accept;
    logic [NUM_CHANNELS-1:0] grant;
    logic [CH_W-1:0]        sel_ch;
    logic                   grant_any;

    logic [DATA_BITS-1:0]   ch_sample [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   ref_vec   [NUM_CHANNELS];
    logic [IDX_W-1:0]       idx_vec   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] wrapped_vec;
    logic                   all_wrapped;

    logic [DATA_BITS-1:0]   sample_sel;
    logic [DATA_BITS-1:0]   ref_sel;
    logic [IDX_W-1:0]       idx_sel;
    logic [DATA_BITS:0]     diff;
    logic                   emit_diff;
    logic                   emit;
    logic                   load;

    assign can_accept  = !valid_reg || ready_i;
    assign all_wrapped = &wrapped_vec;

    // Rotating-priority search; grants are suppressed while held in reset
    // so ch_ready_o reads zero for the whole reset window.
    always_comb begin
        logic [CH_W:0] cand;
        grant     = '0;
        sel_ch    = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            cand = {1'b0, last_grant_reg} + (CH_W+1)'(k + 1);
            if (cand >= (CH_W+1)'(NUM_CHANNELS)) begin
                cand = cand - (CH_W+1)'(NUM_CHANNELS);
            end
            if (!grant_any && ch_valid_i[cand[CH_W-1:0]]) begin
                grant_any = 1'b1;
                sel_ch    = cand[CH_W-1:0];
            end
        end
        if (!can_accept || !rst_ni) begin
            grant_any = 1'b0;
        end else if (grant_any) begin
            grant[sel_ch] = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            logic [DATA_BITS-1:0] ref_reg;
            logic [IDX_W-1:0]     idx_reg;
            logic                 wrapped_reg;
            logic                 wrap;

            assign ch_sample[gi]   = ch_data_i[gi*DATA_BITS +: DATA_BITS];
            assign wrap            = grant[gi] && (idx_reg == IDX_W'(SAMPLES_PER_CHANNEL - 1));
            assign ref_vec[gi]     = ref_reg;
            assign idx_vec[gi]     = idx_reg;
            assign wrapped_vec[gi] = wrapped_reg;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ref_reg     <= '0;
                    idx_reg     <= '0;
                    wrapped_reg <= 1'b0;
                end else begin
                    if (grant[gi]) begin
                        idx_reg <= wrap ? '0 : idx_reg + IDX_W'(1);
                        if (emit) begin
                            ref_reg <= sample_sel;
                        end
                    end
                    // A wrap landing on the clear cycle starts the next frame's flag.
                    if (all_wrapped) begin
                        wrapped_reg <= wrap;
                    end else if (wrap) begin
                        wrapped_reg <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        sample_sel = ch_sample[sel_ch];
        ref_sel    = ref_vec[sel_ch];
        idx_sel    = idx_vec[sel_ch];
        if (sample_sel >= ref_sel) begin
            diff = {1'b0, sample_sel} - {1'b0, ref_sel};
        end else begin
            diff = {1'b0, ref_sel} - {1'b0, sample_sel};
        end
        emit_diff = (32'(diff) >= $unsigned(THRESHOLD));
`ifdef LAVA_SCHED_FORCE_FIRST_EN
        emit = emit_diff || (idx_sel == '0);
`else
        emit = emit_diff;
`endif
        load = grant_any && emit;
    end

    always_comb begin
        valid_next = load || (valid_reg && !ready_i);
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|ch_valid_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (valid_reg && !ready_i) begin
                    state_next = ST_STALL;
                end else if (!(|ch_valid_i) && !valid_next) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (ready_i) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= CH_W'(NUM_CHANNELS - 1);
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_done_reg <= all_wrapped;
            if (grant_any) begin
                last_grant_reg <= sel_ch;
            end
            // Loading takes priority over draining so tokens stream without bubbles.
            if (load) begin
                data_reg  <= {sel_ch, sample_sel, idx_sel};
                valid_reg <= 1'b1;
            end else if (ready_i) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign ch_ready_o   = grant;
    assign data_o       = data_reg;
    assign valid_o      = valid_reg;
    assign frame_done_o = frame_done_reg;

endmodule

// File: tb/tb_lava_channel_scheduler.sv
// Directed bench for lava_channel_scheduler at default parameters (4 channels, 10-bit samples, threshold 20, 3328 samples/frame).
module tb_lava_channel_scheduler;

    localparam int N   = 4;
    localparam int DB  = 10;
    localparam int SPC = 3328;
    localparam int TW  = 2 + DB + 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N*DB-1:0] ch_data = '0;
    logic [N-1:0]    ch_valid = '0;
    logic [N-1:0]    ch_ready;
    logic [TW-1:0]   data;
    logic            valid;
    logic            ready = 1'b1;
    logic            frame_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lava_channel_scheduler dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ch_data_i    (ch_data),
        .ch_valid_i   (ch_valid),
        .ch_ready_o   (ch_ready),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .frame_done_o (frame_done)
    );

    function automatic logic [TW-1:0] tok(input int ch, input int v, input int i);
        return {2'(ch), 10'(v), 12'(i)};
    endfunction

    task automatic set_all(input int v);
        for (int c = 0; c < N; c++) ch_data[c*DB +: DB] = DB'(v);
    endtask

    task automatic set_ch(input int ch, input int v);
        ch_data[ch*DB +: DB] = DB'(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ch_valid = '0; ready = 1'b1; ch_data = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; #1; rst_n = 1'b0;
        ch_valid = '1; set_all(300); #2;
        repeat (2) @(posedge clk); #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid); end
        vectors++; if (data !== '0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", data); end
        vectors++; if (ch_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b expected 0000", ch_ready); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        ch_valid = '0; rst_n = 1'b1; #1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        set_ch(0, 25); ch_valid = 4'b0001; #1;
        vectors++; if (ch_ready !== 4'b0001) begin miscompares++; $display("FAIL single_ready: got %b expected 0001", ch_ready); end
        @(posedge clk); #1; ch_valid = '0;
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b expected 1", valid); end
        vectors++; if (data !== tok(0, 25, 0)) begin miscompares++; $display("FAIL single_data: got %h expected %h", data, tok(0, 25, 0)); end
        @(posedge clk); #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL single_drain: got %b expected 0", valid); end
        $display("test_single: token %h", tok(0, 25, 0));
    endtask

    task automatic test_threshold();
        int vals [8] = '{25, 30, 44, 46, 0, 20, 1, 0};
        bit exp_emit [8] = '{1, 0, 0, 1, 1, 1, 0, 1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_ch(0, vals[i]); ch_valid = 4'b0001; #1;
            vectors++; if (ch_ready !== 4'b0001) begin miscompares++; $display("FAIL thr_ready[%0d]: got %b expected 0001", i, ch_ready); end
            @(posedge clk); #1;
            vectors++; if (valid !== exp_emit[i]) begin miscompares++; $display("FAIL thr_valid[%0d]: got %b expected %b", i, valid, exp_emit[i]); end
            if (exp_emit[i]) begin
                vectors++; if (data !== tok(0, vals[i], i)) begin miscompares++; $display("FAIL thr_data[%0d]: got %h expected %h", i, data, tok(0, vals[i], i)); end
            end
            $display("test_threshold: sample %0d value %0d emit %0d", i, vals[i], exp_emit[i]);
        end
        ch_valid = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        ch_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            set_all(100 * (k / 4 + 1)); #1;
            vectors++; if (ch_ready !== 4'(1 << (k % 4))) begin miscompares++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, ch_ready, 4'(1 << (k % 4))); end
            @(posedge clk); #1;
            vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL rr_valid[%0d]: got %b expected 1", k, valid); end
            vectors++; if (data !== tok(k % 4, 100 * (k / 4 + 1), k / 4)) begin miscompares++; $display("FAIL rr_data[%0d]: got %h expected %h", k, data, tok(k % 4, 100 * (k / 4 + 1), k / 4)); end
            $display("test_back_to_back: cycle %0d grant ch%0d", k, k % 4);
        end
        ch_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        do_reset();
        set_all(100); ch_valid = 4'b1111; #1;
        @(posedge clk); #1;
        ready = 1'b0; #1;
        vectors++; if (ch_ready !== 4'b0000) begin miscompares++; $display("FAIL stall_ready_first: got %b expected 0000", ch_ready); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++; if (2'(dut.state_reg) !== 2'd2) begin miscompares++; $display("FAIL stall_state[%0d]: got %0d expected 2", i, 2'(dut.state_reg)); end
            vectors++; if (valid !== 1'b1 || data !== tok(0, 100, 0)) begin miscompares++; $display("FAIL stall_hold[%0d]: got %b/%h expected 1/%h", i, valid, data, tok(0, 100, 0)); end
            vectors++; if (ch_ready !== 4'b0000) begin miscompares++; $display("FAIL stall_ready[%0d]: got %b expected 0000", i, ch_ready); end
            $display("test_stall: stalled cycle %0d", i);
        end
        ready = 1'b1; #1;
        vectors++; if (ch_ready !== 4'b0010) begin miscompares++; $display("FAIL stall_resume_ready: got %b expected 0010", ch_ready); end
        @(posedge clk); #1;
        vectors++; if (valid !== 1'b1 || data !== tok(1, 100, 0)) begin miscompares++; $display("FAIL stall_resume_data: got %b/%h expected 1/%h", valid, data, tok(1, 100, 0)); end
        vectors++; if (2'(dut.state_reg) !== 2'd1) begin miscompares++; $display("FAIL stall_resume_state: got %0d expected 1", 2'(dut.state_reg)); end
        ch_valid = '0;
        $display("test_stall: resumed at ch1");
    endtask

    task automatic test_force_first();
        do_reset();
        set_ch(1, 5); ch_valid = 4'b0010; #1;
        vectors++; if (ch_ready !== 4'b0010) begin miscompares++; $display("FAIL ff_ready: got %b expected 0010", ch_ready); end
        @(posedge clk); #1;
`ifdef LAVA_SCHED_FORCE_FIRST_EN
        vectors++; if (valid !== 1'b1 || data !== tok(1, 5, 0)) begin miscompares++; $display("FAIL ff_anchor: got %b/%h expected 1/%h", valid, data, tok(1, 5, 0)); end
`else
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL ff_no_anchor: got %b expected 0", valid); end
`endif
        @(posedge clk); #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL ff_second: got %b expected 0", valid); end
        set_ch(1, 30);
        @(posedge clk); #1;
        vectors++; if (valid !== 1'b1 || data !== tok(1, 30, 2)) begin miscompares++; $display("FAIL ff_third: got %b/%h expected 1/%h", valid, data, tok(1, 30, 2)); end
        ch_valid = '0;
        $display("test_force_first: ch1 samples 5,5,30");
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_ch(2, 50); ch_valid = 4'b0100; #1;
        @(posedge clk); #1;
        ch_valid = '0; ready = 1'b0;
        @(posedge clk); #1;
        vectors++; if (valid !== 1'b1 || data !== tok(2, 50, 0)) begin miscompares++; $display("FAIL mid_pending: got %b/%h expected 1/%h", valid, data, tok(2, 50, 0)); end
        #2 rst_n = 1'b0; #1;
        vectors++; if (valid !== 1'b0 || data !== '0) begin miscompares++; $display("FAIL mid_async_clear: got %b/%h expected 0/0", valid, data); end
        @(posedge clk); #1;
        rst_n = 1'b1; ready = 1'b1; set_ch(2, 77); ch_valid = 4'b0100; #1;
        @(posedge clk); #1;
        vectors++; if (valid !== 1'b1 || data !== tok(2, 77, 0)) begin miscompares++; $display("FAIL mid_first_token: got %b/%h expected 1/%h", valid, data, tok(2, 77, 0)); end
        ch_valid = '0;
        $display("test_reset_mid: post-reset token %h", tok(2, 77, 0));
    endtask

    task automatic test_frame();
        int early = 0;
        int late = 0;
        do_reset();
        set_all(100); ch_valid = 4'b1111;
        for (int k = 0; k < N * SPC; k++) begin
            @(posedge clk); #1;
            if (frame_done) early++;
        end
        ch_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (frame_done) late++;
        end
        vectors++; if (early !== 0) begin miscompares++; $display("FAIL frame_early: got %0d pulses expected 0", early); end
        vectors++; if (late !== 1) begin miscompares++; $display("FAIL frame_pulse: got %0d cycles expected 1", late); end
        set_ch(0, 500); ch_valid = 4'b0001; #1;
        @(posedge clk); #1;
        vectors++; if (valid !== 1'b1 || data !== tok(0, 500, 0)) begin miscompares++; $display("FAIL frame_wrap_idx: got %b/%h expected 1/%h", valid, data, tok(0, 500, 0)); end
        ch_valid = '0;
        $display("test_frame: %0d samples, frame_done cycles %0d", N * SPC, late);
    endtask

    initial begin
        test_reset();
        test_single();
        test_threshold();
        test_back_to_back();
        test_stall();
        test_force_first();
        test_reset_mid();
        test_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
